// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, frames 11-bit packets,
// folds E0/F0 prefixes into key events and buffers them in a FWFT FIFO.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_W          = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PS2_DATA,
  input  logic             PS2_CLOCK,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             frame_err,
  output logic             overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  state_t            state;
  logic              clk_s1, clk_s2, clk_prev;
  logic              data_s1, data_s2;
  logic              fall;
  logic [3:0]        bit_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [9:0]        shreg;
  logic              byte_valid;
  logic [7:0]        byte_data;

  logic              ext_flag, brk_flag;
  logic [9:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic              is_prefix, push, pop, full, wr_en;
  logic [9:0]        head;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= PS2_CLOCK;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= PS2_DATA;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // Frame receiver: bits land LSB first, so after 10 shifts shreg = {stop, parity, data}.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      shreg      <= '0;
      frame_err  <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
    end else begin
      frame_err  <= 1'b0;
      byte_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fall && !data_s2) begin
            state   <= RECV;
            bit_cnt <= '0;
            to_cnt  <= '0;
          end
        end
        RECV: begin
          if (fall) begin
            shreg  <= {data_s2, shreg[9:1]};
            to_cnt <= '0;
            if (bit_cnt == 4'd9) state <= CHECK;
            else                 bit_cnt <= bit_cnt + 4'd1;
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        CHECK: begin
          if ((^shreg[8:0]) && shreg[9]) begin
            byte_valid <= 1'b1;
            byte_data  <= shreg[7:0];
          end else begin
            frame_err <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    is_prefix = (byte_data == 8'hE0) || (byte_data == 8'hF0);
    push      = byte_valid && !is_prefix;
    pop       = key_valid && key_ready;
    full      = (fifo_count == CNT_W'(FIFO_DEPTH));
    wr_en     = push && (!full || pop);
  end

  // Decoder flags and FIFO; a full FIFO still accepts a push when the head is popped that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      overflow <= push && full && !pop;
      if (frame_err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_valid) begin
        if (byte_data == 8'hE0)      ext_flag <= 1'b1;
        else if (byte_data == 8'hF0) brk_flag <= 1'b1;
        else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end
      if (wr_en) begin
        mem[wr_ptr] <= {ext_flag, brk_flag, byte_data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!wr_en && pop) fifo_count <= fifo_count - 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign key_code  = head[7:0];
  assign key_break = head[8];
  assign key_ext   = head[9];
  assign key_valid = (fifo_count != '0);

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-bangs PS/2 frames and checks decoded
// events, error pulses, overflow and FIFO ordering against hand-computed values.
module tb_ps2_key_decoder;

  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_data;
  logic       ps2_clock;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_ext, key_break, key_valid;
  logic [2:0] fifo_count;
  logic       frame_err, overflow;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int ovf_pulses = 0;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .PS2_DATA(ps2_data), .PS2_CLOCK(ps2_clock),
    .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
    .key_valid(key_valid), .key_ready(key_ready), .fifo_count(fifo_count),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) err_pulses++;
    if (overflow)  ovf_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(4);
    ps2_clock = 1'b0;
    tick(8);
    ps2_clock = 1'b1;
    tick(4);
  endtask

  // mode 0: plain frame; 1: check key_valid latency; 2: pop on the push cycle
  task automatic send_frame(input logic [7:0] b, input bit flip, input int mode);
    logic [9:0] bits;
    bits = {(~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
    tick(4);
    ps2_clock = 1'b0;
    if (mode == 1) begin
      tick(4);
      check("latency_pre", key_valid, 1'b0);
      tick(1);
      check("latency_rise", key_valid, 1'b1);
      tick(3);
    end else if (mode == 2) begin
      tick(4);
      key_ready = 1'b1;
      tick(1);
      key_ready = 1'b0;
      tick(3);
    end else begin
      tick(8);
    end
    ps2_clock = 1'b1;
    tick(8);
  endtask

  task automatic pop_one();
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int obase;
    rst = 1'b1; ps2_data = 1'b1; ps2_clock = 1'b1; key_ready = 1'b0;
    tick(5);
    check("rst_valid", key_valid, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_code", key_code, 8'h00);
    check("rst_ext", key_ext, 1'b0);
    check("rst_brk", key_break, 1'b0);
    rst = 1'b0;
    tick(4);

    // Plain make code with latency check
    send_frame(8'h1C, 1'b0, 1);
    check("mk_valid", key_valid, 1'b1);
    check("mk_code", key_code, 8'h1C);
    check("mk_ext", key_ext, 1'b0);
    check("mk_brk", key_break, 1'b0);
    check("mk_count", fifo_count, 3'd1);
    pop_one();
    check("mk_pop_count", fifo_count, 3'd0);

    // Break code
    send_frame(8'hF0, 1'b0, 0);
    check("f0_nopush", fifo_count, 3'd0);
    send_frame(8'h1C, 1'b0, 0);
    check("brk_count", fifo_count, 3'd1);
    check("brk_code", key_code, 8'h1C);
    check("brk_brk", key_break, 1'b1);
    check("brk_ext", key_ext, 1'b0);
    pop_one();

    // Extended break, then plain repeat of same code
    send_frame(8'hE0, 1'b0, 0);
    send_frame(8'hF0, 1'b0, 0);
    check("e0f0_nopush", fifo_count, 3'd0);
    send_frame(8'h75, 1'b0, 0);
    check("ebrk_code", key_code, 8'h75);
    check("ebrk_ext", key_ext, 1'b1);
    check("ebrk_brk", key_break, 1'b1);
    send_frame(8'h75, 1'b0, 0);
    check("rep_count", fifo_count, 3'd2);
    pop_one();
    check("rep_code", key_code, 8'h75);
    check("rep_ext", key_ext, 1'b0);
    check("rep_brk", key_break, 1'b0);
    pop_one();
    check("rep_empty", fifo_count, 3'd0);

    // Parity error clears pending E0
    send_frame(8'hE0, 1'b0, 0);
    base = err_pulses;
    send_frame(8'h1C, 1'b1, 0);
    check("par_err_pulse", err_pulses - base, 1);
    check("par_count", fifo_count, 3'd0);
    send_frame(8'h1C, 1'b0, 0);
    check("par_after_code", key_code, 8'h1C);
    check("par_after_ext", key_ext, 1'b0);
    check("par_after_brk", key_break, 1'b0);
    pop_one();

    // Timeout mid-frame
    base = err_pulses;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    for (int i = 0; i < TO + 50 && err_pulses == base; i++) tick(1);
    check("to_err_pulse", err_pulses - base, 1);
    tick(5);
    check("to_err_single", err_pulses - base, 1);
    check("to_count", fifo_count, 3'd0);
    send_frame(8'h5A, 1'b0, 0);
    check("to_after_code", key_code, 8'h5A);
    check("to_after_count", fifo_count, 3'd1);
    pop_one();

    // Overflow with key_ready low
    obase = ovf_pulses;
    send_frame(8'h15, 1'b0, 0);
    send_frame(8'h16, 1'b0, 0);
    send_frame(8'h17, 1'b0, 0);
    send_frame(8'h18, 1'b0, 0);
    send_frame(8'h19, 1'b0, 0);
    check("ovf_count", fifo_count, 3'd4);
    check("ovf_pulse", ovf_pulses - obase, 1);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] exp_code;
      exp_code = 8'h15 + 8'(k);
      check("ovf_drain_code", key_code, exp_code);
      pop_one();
    end
    check("ovf_drain_empty", fifo_count, 3'd0);

    // Push and pop on the same cycle while full
    obase = ovf_pulses;
    send_frame(8'h21, 1'b0, 0);
    send_frame(8'h22, 1'b0, 0);
    send_frame(8'h23, 1'b0, 0);
    send_frame(8'h24, 1'b0, 0);
    check("full_count", fifo_count, 3'd4);
    send_frame(8'h25, 1'b0, 2);
    check("pp_count", fifo_count, 3'd4);
    check("pp_no_ovf", ovf_pulses - obase, 0);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] exp_code;
      exp_code = 8'h22 + 8'(k);
      check("pp_drain_code", key_code, exp_code);
      pop_one();
    end
    check("pp_drain_empty", fifo_count, 3'd0);

    // Reset mid-frame
    base = err_pulses;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    rst = 1'b1;
    tick(3);
    ps2_data = 1'b1;
    rst = 1'b0;
    tick(4);
    check("midrst_no_err", err_pulses - base, 0);
    check("midrst_count", fifo_count, 3'd0);
    send_frame(8'h33, 1'b0, 0);
    check("midrst_code", key_code, 8'h33);
    check("midrst_count1", fifo_count, 3'd1);
    check("midrst_ext", key_ext, 1'b0);
    check("midrst_err_none", err_pulses - base, 0);
    pop_one();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
